round_referee: RTL and testbench

//  Upstream judge for game_sm. Watches the one-hot round state, counts coin pickups and

---
 rtl/round_referee.sv | 128 ++++++++++++
 tb/tb_round_referee.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/round_referee.sv
// Round referee for game_sm: counts coins, detects player/enemy overlap per frame,
// and emits the round-won / collision pulses that advance or reset the game.
module round_referee #(
  parameter int COORD_W    = 10,
  parameter int HIT_BOX    = 16,
  parameter int HIT_FRAMES = 2,
  parameter int CNT_W      = 4,
  parameter int COINS_R1   = 4,
  parameter int COINS_R2   = 6,
  parameter int COINS_R3   = 8,
  parameter int COINS_R4   = 10
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic [5:0]         state,
  input  logic               frame_tick,
  input  logic               coin_hit,
  input  logic [COORD_W-1:0] player_x,
  input  logic [COORD_W-1:0] player_y,
  input  logic [COORD_W-1:0] enemy_x,
  input  logic [COORD_W-1:0] enemy_y,
  output logic               wonFirstRound,
  output logic               wonSecondRound,
  output logic               wonThirdRound,
  output logic               wonFourthRound,
  output logic               collidedWithEnemy,
  output logic [CNT_W-1:0]   coin_count,
  output logic               round_active
);

  localparam int HW = (HIT_FRAMES < 2) ? 1 : $clog2(HIT_FRAMES + 1);
  localparam logic [HW-1:0]      HF = HW'(HIT_FRAMES);
  localparam logic [COORD_W:0]   HB = (COORD_W + 1)'(HIT_BOX);
  localparam logic [5:0] S_INI = 6'b000001;

  typedef enum logic [1:0] {IDLE, PLAY, DONE} fsm_t;

  fsm_t             r_fsm, w_fsm_nxt;
  logic [5:0]       r_prev_state;
  logic [HW-1:0]    r_hit_cnt, w_hit_nxt;
  logic [CNT_W-1:0] r_coins, w_coins_nxt, w_target;
  logic [3:0]       r_won, w_won_nxt, w_round;
  logic             r_coll, w_coll_nxt;
  logic             r_active;
  logic             w_change, w_overlap;
  logic [COORD_W:0] w_px, w_py, w_ex, w_ey, w_dx, w_dy;

  assign w_change = (state != r_prev_state);

  // Absolute differences one bit wider than the coordinates so nothing wraps
  assign w_px = {1'b0, player_x};
  assign w_py = {1'b0, player_y};
  assign w_ex = {1'b0, enemy_x};
  assign w_ey = {1'b0, enemy_y};
  assign w_dx = (w_px >= w_ex) ? (w_px - w_ex) : (w_ex - w_px);
  assign w_dy = (w_py >= w_ey) ? (w_py - w_ey) : (w_ey - w_py);
  assign w_overlap = (w_dx < HB) && (w_dy < HB);

  always_comb begin
    w_target = '0;
    w_round  = 4'b0000;
    case (state)
      6'b000010: begin w_target = CNT_W'(COINS_R1); w_round = 4'b0001; end
      6'b000100: begin w_target = CNT_W'(COINS_R2); w_round = 4'b0010; end
      6'b001000: begin w_target = CNT_W'(COINS_R3); w_round = 4'b0100; end
      6'b010000: begin w_target = CNT_W'(COINS_R4); w_round = 4'b1000; end
      default: ;
    endcase
  end

  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_coins_nxt = r_coins;
    w_hit_nxt   = r_hit_cnt;
    w_won_nxt   = 4'b0000;
    w_coll_nxt  = 1'b0;
    if (w_change) begin
      w_coins_nxt = '0;
      w_hit_nxt   = '0;
      w_fsm_nxt   = (|w_round) ? PLAY : IDLE;
    end else if (r_fsm == PLAY) begin
      if (coin_hit && (r_coins < w_target)) begin
        w_coins_nxt = r_coins + CNT_W'(1);
        if (w_coins_nxt == w_target) w_won_nxt = w_round;
      end
      if (frame_tick) begin
        if (!w_overlap) begin
          w_hit_nxt = '0;
        end else if (r_hit_cnt < HF) begin
          w_hit_nxt = r_hit_cnt + HW'(1);
          if (w_hit_nxt == HF) w_coll_nxt = 1'b1;
        end
      end
      // The player loses a tie between a won round and a collision
      if (w_coll_nxt) w_won_nxt = 4'b0000;
      if (w_coll_nxt || (|w_won_nxt)) w_fsm_nxt = DONE;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_fsm        <= IDLE;
      r_prev_state <= S_INI;
      r_hit_cnt    <= '0;
      r_coins      <= '0;
      r_won        <= 4'b0000;
      r_coll       <= 1'b0;
      r_active     <= 1'b0;
    end else begin
      r_fsm        <= w_fsm_nxt;
      r_prev_state <= state;
      r_hit_cnt    <= w_hit_nxt;
      r_coins      <= w_coins_nxt;
      r_won        <= w_won_nxt;
      r_coll       <= w_coll_nxt;
      r_active     <= (w_fsm_nxt == PLAY);
    end
  end

  assign wonFirstRound     = r_won[0];
  assign wonSecondRound    = r_won[1];
  assign wonThirdRound     = r_won[2];
  assign wonFourthRound    = r_won[3];
  assign collidedWithEnemy = r_coll;
  assign coin_count        = r_coins;
  assign round_active      = r_active;

endmodule

// File: tb/tb_round_referee.sv
// Directed table-driven bench for round_referee.
// Outputs are compared 1 time unit after each rising clock edge.
module tb_round_referee;

  localparam logic [5:0] INI = 6'b000001;
  localparam logic [5:0] R1  = 6'b000010;
  localparam logic [5:0] R2  = 6'b000100;
  localparam logic [5:0] R3  = 6'b001000;
  localparam logic [5:0] R4  = 6'b010000;
  localparam logic [5:0] WIN = 6'b100000;
  localparam logic [5:0] BAD = 6'b000110;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] state;
  logic       frame_tick, coin_hit;
  logic [9:0] player_x, player_y, enemy_x, enemy_y;
  logic       won1, won2, won3, won4, coll, active;
  logic [3:0] coin_count;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [5:0] st;
    logic       c;
    logic       t;
    int         px, py, ex, ey;
    logic [3:0] won;
    logic       coll;
    int         cnt;
    logic       act;
  } vec_t;

  vec_t vq[$];

  round_referee dut (
    .Clk(Clk), .Reset(Reset), .state(state),
    .frame_tick(frame_tick), .coin_hit(coin_hit),
    .player_x(player_x), .player_y(player_y),
    .enemy_x(enemy_x), .enemy_y(enemy_y),
    .wonFirstRound(won1), .wonSecondRound(won2),
    .wonThirdRound(won3), .wonFourthRound(won4),
    .collidedWithEnemy(coll), .coin_count(coin_count),
    .round_active(active)
  );

  always #5 Clk = ~Clk;

  function automatic logic [9:0] pack(logic [3:0] w, logic cl, logic [3:0] n, logic a);
    return {w, cl, n, a};
  endfunction

  task automatic check(string n, logic [9:0] exp);
    logic [9:0] got;
    got = {won4, won3, won2, won1, coll, coin_count, active};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got won=%b coll=%b cnt=%0d act=%b, expected won=%b coll=%b cnt=%0d act=%b",
               n, got[9:6], got[5], got[4:1], got[0],
               exp[9:6], exp[5], exp[4:1], exp[0]);
    end
  endtask

  // Far enemy by default; o=1 places it overlapping the player at (100,100)
  task automatic add(string n, logic [5:0] st, logic c, logic t, logic o,
                     logic [3:0] w, logic cl, int cnt, logic a);
    vec_t v;
    v.name = n; v.st = st; v.c = c; v.t = t;
    v.px = 100; v.py = 100;
    v.ex = o ? 110 : 300; v.ey = o ? 105 : 300;
    v.won = w; v.coll = cl; v.cnt = cnt; v.act = a;
    vq.push_back(v);
  endtask

  task automatic addp(string n, logic [5:0] st, logic t, int px, int py,
                      int ex, int ey, logic cl, logic a);
    vec_t v;
    v.name = n; v.st = st; v.c = 1'b0; v.t = t;
    v.px = px; v.py = py; v.ex = ex; v.ey = ey;
    v.won = 4'b0000; v.coll = cl; v.cnt = 0; v.act = a;
    vq.push_back(v);
  endtask

  task automatic drive(logic [5:0] st, logic c, logic t);
    state = st; coin_hit = c; frame_tick = t;
    @(posedge Clk);
    #1;
  endtask

  initial begin
    Reset = 1'b1; state = INI; coin_hit = 0; frame_tick = 0;
    player_x = 100; player_y = 100; enemy_x = 300; enemy_y = 300;

    // round 1: four coins win, fifth is ignored
    add("r1_enter", R1, 0, 0, 0, 4'b0000, 0, 0, 1);
    add("r1_c1",    R1, 1, 0, 0, 4'b0000, 0, 1, 1);
    add("r1_quiet", R1, 0, 0, 0, 4'b0000, 0, 1, 1);
    add("r1_c2",    R1, 1, 0, 0, 4'b0000, 0, 2, 1);
    add("r1_c3",    R1, 1, 0, 0, 4'b0000, 0, 3, 1);
    add("r1_c4",    R1, 1, 0, 0, 4'b0001, 0, 4, 0);
    add("r1_after", R1, 0, 0, 0, 4'b0000, 0, 4, 0);
    add("r1_c5",    R1, 1, 0, 0, 4'b0000, 0, 4, 0);
    // switch to round 2 with a coin in the change cycle
    add("sw_r2",    R2, 1, 0, 0, 4'b0000, 0, 0, 1);
    add("r2_c1",    R2, 1, 0, 0, 4'b0000, 0, 1, 1);
    add("r2_t1",    R2, 0, 1, 1, 4'b0000, 0, 1, 1);
    add("r2_t2",    R2, 0, 1, 1, 4'b0000, 1, 1, 0);
    add("r2_done",  R2, 0, 1, 1, 4'b0000, 0, 1, 0);
    // non-overlapping frame between ticks restarts the count
    add("ini_a",    INI, 0, 0, 0, 4'b0000, 0, 0, 0);
    add("r2b_in",   R2, 0, 0, 0, 4'b0000, 0, 0, 1);
    add("r2b_t1",   R2, 0, 1, 1, 4'b0000, 0, 0, 1);
    add("r2b_gap",  R2, 0, 1, 0, 4'b0000, 0, 0, 1);
    add("r2b_t2",   R2, 0, 1, 1, 4'b0000, 0, 0, 1);
    add("r2b_hold", R2, 0, 0, 1, 4'b0000, 0, 0, 1);
    add("r2b_t3",   R2, 0, 1, 1, 4'b0000, 1, 0, 0);
    // hit box edges: 15 overlaps, 16 does not
    add("ini_b",    INI, 0, 0, 0, 4'b0000, 0, 0, 0);
    add("r4_in",    R4, 0, 0, 0, 4'b0000, 0, 0, 1);
    addp("r4_dy16", R4, 1, 100, 100, 85, 84, 0, 1);
    addp("r4_d15",  R4, 1, 100, 100, 85, 85, 0, 1);
    addp("r4_dx16", R4, 1, 100, 100, 116, 100, 0, 1);
    addp("r4_d15b", R4, 1, 100, 100, 115, 115, 0, 1);
    addp("r4_d15c", R4, 1, 100, 100, 115, 115, 1, 0);
    // coordinate extremes must not wrap into an overlap
    add("ini_c",    INI, 0, 0, 0, 4'b0000, 0, 0, 0);
    addp("r4w_in",  R4, 0, 0, 0, 1023, 0, 0, 1);
    addp("r4w_t1",  R4, 1, 0, 0, 1023, 0, 0, 1);
    addp("r4w_t2",  R4, 1, 0, 0, 1023, 0, 0, 1);
    addp("r4w_t3",  R4, 1, 1023, 1023, 0, 1023, 0, 1);
    // round 3: target coin and confirming frame in the same cycle
    add("r3_in",    R3, 0, 0, 0, 4'b0000, 0, 0, 1);
    for (int k = 1; k <= 6; k++)
      add($sformatf("r3_c%0d", k), R3, 1, 0, 0, 4'b0000, 0, k, 1);
    add("r3_c7t",   R3, 1, 1, 1, 4'b0000, 0, 7, 1);
    add("r3_c8t",   R3, 1, 1, 1, 4'b0000, 1, 8, 0);
    // non-play states ignore everything
    add("ini_ev",   INI, 1, 1, 1, 4'b0000, 0, 0, 0);
    add("ini_ev2",  INI, 1, 1, 1, 4'b0000, 0, 0, 0);
    add("win_ev",   WIN, 1, 1, 1, 4'b0000, 0, 0, 0);
    add("win_ev2",  WIN, 1, 1, 1, 4'b0000, 0, 0, 0);
    add("bad_ev",   BAD, 1, 1, 1, 4'b0000, 0, 0, 0);
    add("bad_ev2",  BAD, 1, 1, 1, 4'b0000, 0, 0, 0);
    // final round needs ten coins
    add("fin_in",   R4, 0, 0, 0, 4'b0000, 0, 0, 1);
    for (int k = 1; k <= 9; k++)
      add($sformatf("fin_c%0d", k), R4, 1, 0, 0, 4'b0000, 0, k, 1);
    add("fin_c10",  R4, 1, 0, 0, 4'b1000, 0, 10, 0);
    add("fin_after",R4, 1, 0, 0, 4'b0000, 0, 10, 0);

    repeat (2) @(posedge Clk);
    #1;
    check("reset_state", pack(4'b0000, 0, 4'd0, 0));
    Reset = 1'b0;

    foreach (vq[i]) begin
      player_x = vq[i].px[9:0]; player_y = vq[i].py[9:0];
      enemy_x  = vq[i].ex[9:0]; enemy_y  = vq[i].ey[9:0];
      drive(vq[i].st, vq[i].c, vq[i].t);
      check(vq[i].name, pack(vq[i].won, vq[i].coll, vq[i].cnt[3:0], vq[i].act));
    end

    // asynchronous reset in the middle of round 1
    player_x = 100; player_y = 100; enemy_x = 300; enemy_y = 300;
    drive(INI, 0, 0);
    drive(R1, 0, 0);
    for (int k = 1; k <= 3; k++) drive(R1, 1, 0);
    check("rst_pre", pack(4'b0000, 0, 4'd3, 1));
    coin_hit = 0;
    #2 Reset = 1'b1;
    #1 check("rst_async", pack(4'b0000, 0, 4'd0, 0));
    @(posedge Clk);
    #1 Reset = 1'b0;
    drive(R1, 0, 0);
    check("rst_reenter", pack(4'b0000, 0, 4'd0, 1));
    for (int k = 1; k <= 3; k++) drive(R1, 1, 0);
    check("rst_c3", pack(4'b0000, 0, 4'd3, 1));
    drive(R1, 1, 0);
    check("rst_c4", pack(4'b0001, 0, 4'd4, 0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
